// File: rtl/sr04_echo_responder.sv
// HC-SR04 sensor stand-in: qualifies trig, waits the burst delay,
// then returns an echo whose width encodes distance_cm.
module sr04_echo_responder #(
  parameter int unsigned CLK_PER_US    = 100,
  parameter int unsigned US_PER_CM     = 58,
  parameter int unsigned TRIG_MIN_US   = 10,
  parameter int unsigned ECHO_DELAY_US = 200,
  parameter int unsigned MIN_CM        = 2,
  parameter int unsigned MAX_CM        = 400,
  parameter int unsigned TIMEOUT_US    = 38000,
  parameter int unsigned HOLDOFF_US    = 60000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        trig,
  input  logic [11:0] distance_cm,
  input  logic        obj_valid,
  output logic        echo,
  output logic        busy,
  output logic        trig_err,
  output logic        done
);

  typedef enum logic [2:0] {
    IDLE, TRIG_HI, BURST, ECHO, HOLDOFF
  } state_e;

  localparam int unsigned TRIG_CYC = TRIG_MIN_US * CLK_PER_US;
  localparam int unsigned TCW = $clog2(TRIG_CYC + 1);
  localparam int unsigned PW =
    (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;

  localparam logic [PW-1:0]  PRESC_MAX = PW'(CLK_PER_US - 1);
  localparam logic [TCW-1:0] TCNT_MAX  = TCW'(TRIG_CYC);
  localparam logic [TCW-1:0] TCNT_OK   = TCW'(TRIG_CYC - 1);
  localparam logic [15:0]    DLY_LAST  = 16'(ECHO_DELAY_US - 1);
  localparam logic [15:0]    HOLD_LAST = 16'(HOLDOFF_US - 1);
  localparam logic [15:0]    TMO_W     = 16'(TIMEOUT_US);
  localparam logic [15:0]    MIN_W     = 16'(MIN_CM * US_PER_CM);
  localparam logic [15:0]    UPC       = 16'(US_PER_CM);
  localparam logic [11:0]    MAX_D     = 12'(MAX_CM);
  localparam logic [11:0]    MIN_D     = 12'(MIN_CM);

  state_e state_q, state_d;

  logic           sync1_q, sync1_d;
  logic           sync2_q, sync2_d;
  logic           sync3_q, sync3_d;
  logic           rise_q, rise_d;
  logic           fall_q, fall_d;
  logic [PW-1:0]  presc_q, presc_d;
  logic [15:0]    us_q, us_d;
  logic [TCW-1:0] tcnt_q, tcnt_d;
  logic [11:0]    dist_q, dist_d;
  logic           obj_q, obj_d;
  logic [15:0]    width_q, width_d;
  logic           echo_q, echo_d;
  logic           busy_q, busy_d;
  logic           err_q, err_d;
  logic           done_q, done_d;

  logic        us_tick;
  logic        timed;
  logic [15:0] us_last;
  logic        us_done;

  assign us_tick = (presc_q == PRESC_MAX);
  assign timed = (state_q == BURST) || (state_q == ECHO)
              || (state_q == HOLDOFF);

  always_comb begin
    us_last = HOLD_LAST;
    unique case (state_q)
      BURST:   us_last = DLY_LAST;
      ECHO:    us_last = width_q - 16'd1;
      default: us_last = HOLD_LAST;
    endcase
  end

  assign us_done = timed && us_tick && (us_q == us_last);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (rise_q) state_d = TRIG_HI;
      TRIG_HI: if (fall_q)
                 state_d = (tcnt_q >= TCNT_OK) ? BURST : IDLE;
      BURST:   if (us_done) state_d = ECHO;
      ECHO:    if (us_done) state_d = HOLDOFF;
      HOLDOFF: if (us_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    echo_d = (state_d == ECHO);
    busy_d = (state_d == BURST) || (state_d == ECHO)
          || (state_d == HOLDOFF);
    done_d = (state_q == ECHO) && (state_d == HOLDOFF);
    err_d  = (state_q == TRIG_HI) && (state_d == IDLE);
  end

  always_comb begin
    sync1_d = trig;
    sync2_d = sync1_q;
    sync3_d = sync2_q;
    rise_d  = sync2_q & ~sync3_q;
    fall_d  = ~sync2_q & sync3_q;

    // timebase restarts on every state entry
    if (!timed || state_d != state_q) begin
      presc_d = '0;
      us_d    = '0;
    end else begin
      presc_d = us_tick ? '0 : presc_q + PW'(1);
      us_d    = us_tick ? us_q + 16'd1 : us_q;
    end

    tcnt_d = '0;
    if (state_q == TRIG_HI)
      tcnt_d = (tcnt_q == TCNT_MAX) ? tcnt_q : tcnt_q + TCW'(1);

    dist_d = dist_q;
    obj_d  = obj_q;
    if (state_q == TRIG_HI && state_d == BURST) begin
      dist_d = distance_cm;
      obj_d  = obj_valid;
    end

    width_d = width_q;
    if (state_q == BURST) begin
      if (!obj_q || dist_q > MAX_D) width_d = TMO_W;
      else if (dist_q < MIN_D)      width_d = MIN_W;
      else                          width_d = {4'd0, dist_q} * UPC;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      presc_q <= '0;
      us_q    <= '0;
      tcnt_q  <= '0;
      dist_q  <= '0;
      obj_q   <= 1'b0;
      width_q <= '0;
      echo_q  <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      sync3_q <= sync3_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      presc_q <= presc_d;
      us_q    <= us_d;
      tcnt_q  <= tcnt_d;
      dist_q  <= dist_d;
      obj_q   <= obj_d;
      width_q <= width_d;
      echo_q  <= echo_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  assign echo     = echo_q;
  assign busy     = busy_q;
  assign trig_err = err_q;
  assign done     = done_q;

endmodule

// File: tb/tb_sr04_echo_responder.sv
// Randomised bench for sr04_echo_responder with scaled-down timing
// and an event-time reference model.
module tb_sr04_echo_responder;

  localparam int CPU  = 4;
  localparam int UPC  = 3;
  localparam int TMIN = 3;
  localparam int EDLY = 5;
  localparam int MINC = 2;
  localparam int MAXC = 30;
  localparam int TOUT = 100;
  localparam int HOLD = 25;

  localparam int TRIG_CYC = TMIN * CPU;
  localparam int DLY      = 3 + EDLY * CPU;
  localparam int HCYC     = HOLD * CPU;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        trig = 1'b0;
  logic [11:0] distance_cm = '0;
  logic        obj_valid = 1'b0;
  logic        echo, busy, trig_err, done;

  always #5 clk = ~clk;

  sr04_echo_responder #(
    .CLK_PER_US(CPU), .US_PER_CM(UPC), .TRIG_MIN_US(TMIN),
    .ECHO_DELAY_US(EDLY), .MIN_CM(MINC), .MAX_CM(MAXC),
    .TIMEOUT_US(TOUT), .HOLDOFF_US(HOLD)
  ) dut (
    .clk(clk), .reset_n(reset_n), .trig(trig),
    .distance_cm(distance_cm), .obj_valid(obj_valid),
    .echo(echo), .busy(busy), .trig_err(trig_err), .done(done)
  );

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // 0 echo rise, 1 echo fall, 2 busy rise, 3 busy fall,
  // 4 done high cycle, 5 trig_err high cycle
  int     ev_n[6] = '{default: 0};
  longint ev_t[6] = '{default: 0};
  int     base[6] = '{default: 0};
  logic   echo_p = 1'b0;
  logic   busy_p = 1'b0;

  always @(negedge clk) begin
    echo_p <= echo;
    busy_p <= busy;
    if (echo && !echo_p) begin
      ev_n[0] <= ev_n[0] + 1; ev_t[0] <= cyc;
    end
    if (!echo && echo_p) begin
      ev_n[1] <= ev_n[1] + 1; ev_t[1] <= cyc;
    end
    if (busy && !busy_p) begin
      ev_n[2] <= ev_n[2] + 1; ev_t[2] <= cyc;
    end
    if (!busy && busy_p) begin
      ev_n[3] <= ev_n[3] + 1; ev_t[3] <= cyc;
    end
    if (done) begin
      ev_n[4] <= ev_n[4] + 1; ev_t[4] <= cyc;
    end
    if (trig_err) begin
      ev_n[5] <= ev_n[5] + 1; ev_t[5] <= cyc;
    end
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input longint got,
                     input longint exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint exp_w(input int d, input bit ov);
    int us;
    if (!ov || d > MAXC) us = TOUT;
    else if (d < MINC)   us = MINC * UPC;
    else                 us = d * UPC;
    return longint'(us) * CPU;
  endfunction

  task automatic snap();
    for (int k = 0; k < 6; k++) base[k] = ev_n[k];
  endtask

  function automatic int dn(input int k);
    return ev_n[k] - base[k];
  endfunction

  task automatic pulse(input int w, output longint tf);
    @(negedge clk);
    trig = 1'b1;
    repeat (w) @(negedge clk);
    trig = 1'b0;
    tf = cyc + 1;
  endtask

  task automatic wait_ev(input int k, input int budget,
                         input string tag);
    for (int i = 0; i < budget && dn(k) < 1; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    if (dn(k) < 1) chk(tag, dn(k), 1);
  endtask

  // mode: 0 plain, 1 inputs change in BURST, 2 trig in ECHO,
  //       3 trig in HOLDOFF, 4 trig held across HOLDOFF end
  task automatic txn(input int d, input bit ov, input int tw,
                     input int mode);
    longint tf, tx, w;
    w = exp_w(d, ov);
    distance_cm = 12'(d);
    obj_valid = ov;
    snap();
    pulse(tw, tf);
    if (mode == 1) begin
      repeat (5) @(negedge clk);
      distance_cm = 12'($urandom);
      obj_valid = 1'($urandom);
    end
    wait_ev(0, DLY + 20, "to_rise");
    if (mode == 2) pulse(TRIG_CYC + 2, tx);
    wait_ev(1, int'(w) + 50, "to_fall");
    if (mode == 3) begin
      repeat (5) @(negedge clk);
      pulse(TRIG_CYC + 8, tx);
    end
    if (mode == 4) begin
      repeat (5) @(negedge clk);
      trig = 1'b1;
    end
    wait_ev(3, HCYC + 50, "to_idle");
    if (mode == 4) begin
      repeat (10) @(negedge clk);
      trig = 1'b0;
    end
    repeat (DLY + 10) @(negedge clk);
    chk("rise_n", dn(0), 1);
    chk("fall_n", dn(1), 1);
    chk("rise_t", ev_t[0] - tf, DLY);
    chk("echo_w", ev_t[1] - ev_t[0], w);
    chk("done_n", dn(4), 1);
    chk("done_t", ev_t[4], ev_t[1]);
    chk("busy_on", ev_t[2] - tf, 3);
    chk("busy_off", ev_t[3] - ev_t[1], HCYC);
    chk("err_n", dn(5), 0);
  endtask

  task automatic short_trig();
    longint tf;
    distance_cm = 12'd10;
    obj_valid = 1'b1;
    snap();
    pulse(TRIG_CYC - 1, tf);
    repeat (DLY + 20) @(negedge clk);
    chk("serr_n", dn(5), 1);
    chk("serr_t", ev_t[5] - tf, 3);
    chk("serr_echo", dn(0), 0);
    chk("serr_busy", dn(2), 0);
  endtask

  task automatic reset_mid_echo();
    longint tf;
    distance_cm = 12'(MAXC);
    obj_valid = 1'b1;
    snap();
    pulse(TRIG_CYC + 5, tf);
    wait_ev(0, DLY + 20, "rst_rise");
    repeat (40) @(negedge clk);
    chk("rst_pre", echo, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_echo", echo, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("r_echo", echo, 0);
    chk("r_busy", busy, 0);
    chk("r_err", trig_err, 0);
    chk("r_done", done, 0);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);

    txn(10, 1'b1, TRIG_CYC, 0);
    short_trig();
    txn(10, 1'b1, TRIG_CYC, 0);
    txn(1, 1'b1, TRIG_CYC + 3, 0);
    txn(0, 1'b1, TRIG_CYC + 3, 0);
    txn(MINC, 1'b1, TRIG_CYC + 3, 0);
    txn(MAXC, 1'b1, TRIG_CYC + 3, 0);
    txn(MAXC + 1, 1'b1, TRIG_CYC + 3, 0);
    txn(10, 1'b0, TRIG_CYC + 3, 0);
    txn(4095, 1'b1, TRIG_CYC + 3, 0);
    txn(10, 1'b1, TRIG_CYC + 8, 1);
    txn(10, 1'b1, TRIG_CYC + 8, 2);
    txn(10, 1'b1, TRIG_CYC + 8, 3);
    txn(10, 1'b1, TRIG_CYC + 8, 4);
    txn(12, 1'b1, TRIG_CYC + 1, 0);
    reset_mid_echo();
    txn(MAXC, 1'b1, TRIG_CYC, 0);

    for (int i = 0; i < 25; i++) begin
      int d;
      d = (i % 8 == 7) ? int'($urandom_range(0, 4095))
                       : int'($urandom_range(0, MAXC + 4));
      txn(d, $urandom_range(0, 7) != 0,
          int'($urandom_range(TRIG_CYC, TRIG_CYC + 20)),
          int'($urandom_range(0, 4)));
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
